// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer write path.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RENDER = 2'd2,
        DONE   = 2'd3
    } fb_state_t;

    // One pixel write from the raytracing controller (default 16-bit fields).
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] color;
    } pixel_write_t;

    function automatic int fb_pix_bits(input int width, input int height);
        return $clog2(width * height);
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational bounds check and linear pixel index (y*FRAME_WIDTH + x).
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int FRAME_WIDTH  = 512,
    parameter int FRAME_HEIGHT = 384,
    parameter int COORD_BITS   = 16,
    parameter int PIX_BITS     = fb_pix_bits(FRAME_WIDTH, FRAME_HEIGHT)
) (
    input  logic [COORD_BITS-1:0] x,
    input  logic [COORD_BITS-1:0] y,
    output logic                  in_bounds,
    output logic [PIX_BITS-1:0]   pix_addr
);

    localparam int XB = $clog2(FRAME_WIDTH);
    localparam int YB = $clog2(FRAME_HEIGHT);
    localparam logic [COORD_BITS:0] W_LIM = FRAME_WIDTH[COORD_BITS:0];
    localparam logic [COORD_BITS:0] H_LIM = FRAME_HEIGHT[COORD_BITS:0];

    assign in_bounds = ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);

    // Only the low coordinate bits reach the index; out-of-range values are masked by in_bounds.
    generate
        if ((FRAME_WIDTH & (FRAME_WIDTH - 1)) == 0) begin : g_shift
            assign pix_addr = PIX_BITS'({y[YB-1:0], x[XB-1:0]});
        end else begin : g_mult
            localparam logic [PIX_BITS-1:0] W_MUL = FRAME_WIDTH[PIX_BITS-1:0];
            assign pix_addr = PIX_BITS'(y[YB-1:0]) * W_MUL + PIX_BITS'(x[XB-1:0]);
        end
    endgenerate

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel-write front end for frame-buffer BRAM port A: clear, render, ping-pong and stats.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int FRAME_WIDTH  = 512,
    parameter int FRAME_HEIGHT = 384,
    parameter int COLOR_WIDTH  = 16,
    parameter int COORD_BITS   = 16,
    parameter int NUM_BUFFERS  = 2,
    parameter int CNT_BITS     = 64,
    localparam int PIX_BITS    = fb_pix_bits(FRAME_WIDTH, FRAME_HEIGHT),
    localparam int ADDR_BITS   = PIX_BITS + ((NUM_BUFFERS == 2) ? 1 : 0)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   clear_en,
    input  logic [COLOR_WIDTH-1:0] clear_color,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COORD_BITS-1:0]  in_x,
    input  logic [COORD_BITS-1:0]  in_y,
    input  logic [COLOR_WIDTH-1:0] in_color,
    output logic                   bram_we,
    output logic [ADDR_BITS-1:0]   bram_addr,
    output logic [COLOR_WIDTH-1:0] bram_din,
    output logic                   disp_buf,
    output logic                   busy,
    output logic                   frame_done,
    output logic [CNT_BITS-1:0]    cycle_count,
    output logic [31:0]            write_count,
    output logic [15:0]            drop_count
);

    generate
        if (NUM_BUFFERS != 1 && NUM_BUFFERS != 2) begin : g_bad_buffers
            $error("framebuffer_writer: NUM_BUFFERS must be 1 or 2");
        end
    endgenerate

    localparam logic [PIX_BITS-1:0] LAST_PIX = PIX_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);

    fb_state_t               state_reg, state_next;
    logic [COLOR_WIDTH-1:0]  clear_color_reg, clear_color_next;
    logic [PIX_BITS-1:0]     clear_idx_reg, clear_idx_next;
    logic                    disp_buf_reg, disp_buf_next;
    logic                    bram_we_reg, bram_we_next;
    logic [ADDR_BITS-1:0]    bram_addr_reg, bram_addr_next;
    logic [COLOR_WIDTH-1:0]  bram_din_reg, bram_din_next;
    logic [CNT_BITS-1:0]     cycle_count_reg, cycle_count_next;
    logic [31:0]             write_count_reg, write_count_next;
    logic [15:0]             drop_count_reg, drop_count_next;

    logic                    pix_in_bounds;
    logic [PIX_BITS-1:0]     pix_addr;
    logic [ADDR_BITS-1:0]    clear_addr;
    logic [ADDR_BITS-1:0]    wr_addr;

    fb_addr_gen #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .COORD_BITS   (COORD_BITS),
        .PIX_BITS     (PIX_BITS)
    ) u_addr_gen (
        .x         (in_x),
        .y         (in_y),
        .in_bounds (pix_in_bounds),
        .pix_addr  (pix_addr)
    );

    // All writes go to the back buffer, the one VGA is not showing.
    generate
        if (NUM_BUFFERS == 2) begin : g_two_buf
            assign clear_addr = {~disp_buf_reg, clear_idx_reg};
            assign wr_addr    = {~disp_buf_reg, pix_addr};
        end else begin : g_one_buf
            assign clear_addr = clear_idx_reg;
            assign wr_addr    = pix_addr;
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        clear_color_next = clear_color_reg;
        clear_idx_next   = clear_idx_reg;
        disp_buf_next    = disp_buf_reg;
        bram_we_next     = 1'b0;
        bram_addr_next   = bram_addr_reg;
        bram_din_next    = bram_din_reg;
        cycle_count_next = cycle_count_reg;
        write_count_next = write_count_reg;
        drop_count_next  = drop_count_reg;

        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    cycle_count_next = '0;
                    write_count_next = '0;
                    drop_count_next  = '0;
                    clear_color_next = clear_color;
                    clear_idx_next   = '0;
                    state_next       = clear_en ? CLEAR : RENDER;
                end
            end
            CLEAR: begin
                bram_we_next   = 1'b1;
                bram_addr_next = clear_addr;
                bram_din_next  = clear_color_reg;
                clear_idx_next = clear_idx_reg + PIX_BITS'(1);
                if (clear_idx_reg == LAST_PIX) begin
                    state_next = RENDER;
                end
            end
            RENDER: begin
                if (in_valid) begin
                    if (pix_in_bounds) begin
                        bram_we_next     = 1'b1;
                        bram_addr_next   = wr_addr;
                        bram_din_next    = in_color;
                        write_count_next = write_count_reg + 32'd1;
                        // The bottom-right pixel closes the frame regardless of arrival order.
                        if (pix_addr == LAST_PIX) begin
                            state_next = DONE;
                        end
                    end else if (drop_count_reg != 16'hFFFF) begin
                        drop_count_next = drop_count_reg + 16'd1;
                    end
                end
            end
            DONE: begin
                state_next    = IDLE;
                disp_buf_next = (NUM_BUFFERS == 2) ? ~disp_buf_reg : 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if ((state_reg == CLEAR || state_reg == RENDER) && cycle_count_reg != '1) begin
            cycle_count_next = cycle_count_reg + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            clear_color_reg <= '0;
            clear_idx_reg   <= '0;
            disp_buf_reg    <= 1'b0;
            bram_we_reg     <= 1'b0;
            bram_addr_reg   <= '0;
            bram_din_reg    <= '0;
            cycle_count_reg <= '0;
            write_count_reg <= '0;
            drop_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            clear_color_reg <= clear_color_next;
            clear_idx_reg   <= clear_idx_next;
            disp_buf_reg    <= disp_buf_next;
            bram_we_reg     <= bram_we_next;
            bram_addr_reg   <= bram_addr_next;
            bram_din_reg    <= bram_din_next;
            cycle_count_reg <= cycle_count_next;
            write_count_reg <= write_count_next;
            drop_count_reg  <= drop_count_next;
        end
    end

    assign in_ready    = (state_reg == RENDER);
    assign busy        = (state_reg == CLEAR) || (state_reg == RENDER);
    assign frame_done  = (state_reg == DONE);
    assign disp_buf    = disp_buf_reg;
    assign bram_we     = bram_we_reg;
    assign bram_addr   = bram_addr_reg;
    assign bram_din    = bram_din_reg;
    assign cycle_count = cycle_count_reg;
    assign write_count = write_count_reg;
    assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench: 4x3 ping-pong instance plus a 5x3 single-buffer instance.
module tb_framebuffer_writer;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 4x3, two buffers
    logic        frame_start, clear_en, in_valid, in_ready;
    logic [15:0] clear_color, in_x, in_y, in_color;
    logic        bram_we, disp_buf, busy, frame_done;
    logic [4:0]  bram_addr;
    logic [15:0] bram_din, drop_count;
    logic [63:0] cycle_count;
    logic [31:0] write_count;

    // 5x3, one buffer
    logic        frame_start_b, clear_en_b, in_valid_b, in_ready_b;
    logic [15:0] clear_color_b, in_x_b, in_y_b, in_color_b;
    logic        bram_we_b, disp_buf_b, busy_b, frame_done_b;
    logic [3:0]  bram_addr_b;
    logic [15:0] bram_din_b, drop_count_b;
    logic [63:0] cycle_count_b;
    logic [31:0] write_count_b;

    int checks = 0;
    int errors = 0;

    framebuffer_writer #(.FRAME_WIDTH(4), .FRAME_HEIGHT(3), .NUM_BUFFERS(2)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .clear_en(clear_en),
        .clear_color(clear_color), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_color(in_color), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din), .disp_buf(disp_buf), .busy(busy),
        .frame_done(frame_done), .cycle_count(cycle_count), .write_count(write_count),
        .drop_count(drop_count)
    );

    framebuffer_writer #(.FRAME_WIDTH(5), .FRAME_HEIGHT(3), .NUM_BUFFERS(1)) dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start_b), .clear_en(clear_en_b),
        .clear_color(clear_color_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_x(in_x_b), .in_y(in_y_b), .in_color(in_color_b), .bram_we(bram_we_b),
        .bram_addr(bram_addr_b), .bram_din(bram_din_b), .disp_buf(disp_buf_b), .busy(busy_b),
        .frame_done(frame_done_b), .cycle_count(cycle_count_b), .write_count(write_count_b),
        .drop_count(drop_count_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input pixel_write_t p);
        in_valid = 1'b1;
        in_x     = p.x;
        in_y     = p.y;
        in_color = p.color;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        frame_start = 0; clear_en = 0; clear_color = 0; in_valid = 0; in_x = 0; in_y = 0; in_color = 0;
        frame_start_b = 0; clear_en_b = 0; clear_color_b = 0; in_valid_b = 0; in_x_b = 0; in_y_b = 0; in_color_b = 0;
        repeat (3) tick();
        checks++; if ({bram_we, bram_addr, bram_din} !== '0) begin errors++; $display("FAIL reset_bram: got we=%0b addr=%0d din=%h, expected all 0", bram_we, bram_addr, bram_din); end
        checks++; if ({disp_buf, busy, frame_done, in_ready} !== 4'b0) begin errors++; $display("FAIL reset_flags: got disp/busy/done/ready=%b, expected 0000", {disp_buf, busy, frame_done, in_ready}); end
        checks++; if ({cycle_count, write_count, drop_count} !== '0) begin errors++; $display("FAIL reset_counts: got cyc=%0d wr=%0d drop=%0d, expected 0", cycle_count, write_count, drop_count); end

        rst = 1'b1; frame_start = 1'b1; clear_en = 1'b0;
        tick();
        frame_start = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_enter_render: in_ready got %0b, expected 1", in_ready); end
        // Valid write presented in the same cycle the reset lands
        drive_pix('{x:16'd1, y:16'd1, color:16'h1111});
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if ({bram_we, busy, in_ready} !== 3'b000) begin errors++; $display("FAIL reset_abort: we/busy/ready got %b, expected 000", {bram_we, busy, in_ready}); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL reset_hold_we: cycle %0d got %0b, expected 0", i, bram_we); end
        end
        checks++; if (disp_buf !== 1'b0) begin errors++; $display("FAIL reset_disp_buf: got %0b, expected 0", disp_buf); end
        rst = 1'b1;
        tick();
        $display("reset mid-render: aborted, outputs cleared");
    endtask

    task automatic test_clear();
        logic [4:0] exp_addr;
        frame_start = 1'b1; clear_en = 1'b1; clear_color = 16'h0ABC;
        tick();
        frame_start = 1'b0; clear_en = 1'b0; clear_color = 16'h0000;
        checks++; if ({busy, in_ready, bram_we} !== 3'b100) begin errors++; $display("FAIL clear_entry: busy/ready/we got %b, expected 100", {busy, in_ready, bram_we}); end
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_addr = 5'd16 + 5'(i);
            checks++; if (bram_we !== 1'b1 || bram_addr !== exp_addr || bram_din !== 16'h0ABC) begin
                errors++; $display("FAIL clear_write %0d: got we=%0b addr=%0d din=%h, expected we=1 addr=%0d din=0abc", i, bram_we, bram_addr, bram_din, exp_addr);
            end
            $display("clear write %0d: addr=%0d din=%h", i, bram_addr, bram_din);
        end
        checks++; if (in_ready !== 1'b1 || cycle_count !== 64'd12) begin errors++; $display("FAIL clear_to_render: ready=%0b cyc=%0d, expected ready=1 cyc=12", in_ready, cycle_count); end
        tick();
        checks++; if (bram_we !== 1'b0 || cycle_count !== 64'd13) begin errors++; $display("FAIL clear_stop: we=%0b cyc=%0d, expected we=0 cyc=13", bram_we, cycle_count); end
    endtask

    task automatic test_writes();
        drive_pix('{x:16'd1, y:16'd2, color:16'h0F00});
        tick();
        checks++; if (bram_we !== 1'b1 || bram_addr !== 5'd25 || bram_din !== 16'h0F00 || frame_done !== 1'b0) begin
            errors++; $display("FAIL write_1_2: we=%0b addr=%0d din=%h done=%0b, expected 1/25/0f00/0", bram_we, bram_addr, bram_din, frame_done);
        end
        $display("write (1,2): addr=%0d din=%h", bram_addr, bram_din);
        drive_pix('{x:16'd3, y:16'd2, color:16'h00F0});
        tick();
        in_valid = 1'b0;
        checks++; if (bram_we !== 1'b1 || bram_addr !== 5'd27 || bram_din !== 16'h00F0) begin
            errors++; $display("FAIL write_3_2: we=%0b addr=%0d din=%h, expected 1/27/00f0", bram_we, bram_addr, bram_din);
        end
        checks++; if (frame_done !== 1'b1 || write_count !== 32'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL frame1_done: done=%0b wr=%0d ready=%0b, expected 1/2/0", frame_done, write_count, in_ready);
        end
        $display("write (3,2): addr=%0d din=%h frame_done=%0b", bram_addr, bram_din, frame_done);
        tick();
        checks++; if (frame_done !== 1'b0 || disp_buf !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL frame1_after: done=%0b disp=%0b busy=%0b, expected 0/1/0", frame_done, disp_buf, busy);
        end
    endtask

    task automatic test_drops_second_frame();
        frame_start = 1'b1; clear_en = 1'b0;
        tick();
        frame_start = 1'b0;
        checks++; if (bram_we !== 1'b0 || in_ready !== 1'b1 || write_count !== 32'd0) begin
            errors++; $display("FAIL frame2_start: we=%0b ready=%0b wr=%0d, expected 0/1/0", bram_we, in_ready, write_count);
        end
        drive_pix('{x:16'd4, y:16'd0, color:16'hDEAD});
        tick();
        checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL drop_x: we got %0b, expected 0", bram_we); end
        drive_pix('{x:16'd0, y:16'd3, color:16'hBEEF});
        tick();
        in_valid = 1'b0;
        checks++; if (bram_we !== 1'b0 || drop_count !== 16'd2 || in_ready !== 1'b1 || write_count !== 32'd0) begin
            errors++; $display("FAIL drop_y: we=%0b drop=%0d ready=%0b wr=%0d, expected 0/2/1/0", bram_we, drop_count, in_ready, write_count);
        end
        $display("drops (4,0),(0,3): drop_count=%0d", drop_count);
        drive_pix('{x:16'd0, y:16'd0, color:16'h1234});
        tick();
        checks++; if (bram_we !== 1'b1 || bram_addr !== 5'd0 || bram_din !== 16'h1234) begin
            errors++; $display("FAIL frame2_write_0_0: we=%0b addr=%0d din=%h, expected 1/0/1234", bram_we, bram_addr, bram_din);
        end
        drive_pix('{x:16'd3, y:16'd2, color:16'h4321});
        tick();
        in_valid = 1'b0;
        checks++; if (bram_addr !== 5'd11 || frame_done !== 1'b1 || write_count !== 32'd2 || drop_count !== 16'd2) begin
            errors++; $display("FAIL frame2_done: addr=%0d done=%0b wr=%0d drop=%0d, expected 11/1/2/2", bram_addr, frame_done, write_count, drop_count);
        end
        $display("frame 2 last write: addr=%0d", bram_addr);
        tick();
        checks++; if (disp_buf !== 1'b0) begin errors++; $display("FAIL frame2_disp_buf: got %0b, expected 0", disp_buf); end
    endtask

    task automatic test_idle_ignore();
        drive_pix('{x:16'd0, y:16'd0, color:16'h5555});
        repeat (2) tick();
        in_valid = 1'b0;
        checks++; if (bram_we !== 1'b0 || in_ready !== 1'b0 || write_count !== 32'd2) begin
            errors++; $display("FAIL idle_ignore: we=%0b ready=%0b wr=%0d, expected 0/0/2", bram_we, in_ready, write_count);
        end
    endtask

    task automatic test_single_buffer();
        frame_start_b = 1'b1; clear_en_b = 1'b0;
        tick();
        checks++; if (in_ready_b !== 1'b1 || cycle_count_b !== 64'd0) begin
            errors++; $display("FAIL b_start: ready=%0b cyc=%0d, expected 1/0", in_ready_b, cycle_count_b);
        end
        // frame_start (with clear) during RENDER must not restart or clear
        clear_en_b = 1'b1; clear_color_b = 16'hAAAA;
        in_valid_b = 1'b1; in_x_b = 16'd0; in_y_b = 16'd0; in_color_b = 16'h0101;
        tick();
        frame_start_b = 1'b0; clear_en_b = 1'b0;
        checks++; if (bram_we_b !== 1'b1 || bram_addr_b !== 4'd0 || bram_din_b !== 16'h0101 || in_ready_b !== 1'b1) begin
            errors++; $display("FAIL b_ignore_start: we=%0b addr=%0d din=%h ready=%0b, expected 1/0/0101/1", bram_we_b, bram_addr_b, bram_din_b, in_ready_b);
        end
        in_x_b = 16'd4; in_y_b = 16'd2; in_color_b = 16'h7777;
        tick();
        in_valid_b = 1'b0;
        checks++; if (bram_we_b !== 1'b1 || bram_addr_b !== 4'd14 || bram_din_b !== 16'h7777 || frame_done_b !== 1'b1) begin
            errors++; $display("FAIL b_write_4_2: we=%0b addr=%0d din=%h done=%0b, expected 1/14/7777/1", bram_we_b, bram_addr_b, bram_din_b, frame_done_b);
        end
        checks++; if (write_count_b !== 32'd2) begin errors++; $display("FAIL b_write_count: got %0d, expected 2", write_count_b); end
        $display("single-buffer write (4,2): addr=%0d", bram_addr_b);
        tick();
        checks++; if (disp_buf_b !== 1'b0 || busy_b !== 1'b0 || cycle_count_b !== 64'd2) begin
            errors++; $display("FAIL b_after_done: disp=%0b busy=%0b cyc=%0d, expected 0/0/2", disp_buf_b, busy_b, cycle_count_b);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_writes();
        test_drops_second_frame();
        test_idle_ignore();
        test_single_buffer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
